// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator for the VGA text path.
// Default timing is 800x600@72 from a 50 MHz pixel clock.
//
// Ports:
//   clk          pixel clock; all state updates on the rising edge
//   RSTn         asynchronous reset, active low
//   pix_ce       pixel clock enable (only when VGA_TIMING_PIXCE_EN is defined)
//   hcnt, vcnt   raster position; (0,0) is the first visible pixel
//   hsync/vsync  sync pulses, active level set by HPOL/VPOL
//   hvalid       high while hcnt < HVIS
//   vvalid       high while vcnt < VVIS
//   line_start   high while hcnt == 0
//   frame_start  high while hcnt == 0 and vcnt == 0
//
// Optional feature macro: VGA_TIMING_PIXCE_EN
//   defined   : pix_ce port exists; every register holds on edges with pix_ce=0
//   undefined : no pix_ce port; the generator advances on every clk edge

module vga_timing #(
    parameter int unsigned HVIS = 800,
    parameter int unsigned HFP  = 56,
    parameter int unsigned HSW  = 120,
    parameter int unsigned HBP  = 64,
    parameter int unsigned VVIS = 600,
    parameter int unsigned VFP  = 37,
    parameter int unsigned VSW  = 6,
    parameter int unsigned VBP  = 23,
    parameter bit          HPOL = 1'b1,
    parameter bit          VPOL = 1'b1
) (
    input  logic        clk,
    input  logic        RSTn,
`ifdef VGA_TIMING_PIXCE_EN
    input  logic        pix_ce,
`endif
    output logic [10:0] hcnt,
    output logic [10:0] vcnt,
    output logic        hsync,
    output logic        vsync,
    output logic        hvalid,
    output logic        vvalid,
    output logic        line_start,
    output logic        frame_start
);

    localparam int unsigned HTOTAL = HVIS + HFP + HSW + HBP;
    localparam int unsigned VTOTAL = VVIS + VFP + VSW + VBP;

    localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(VTOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(HVIS);
    localparam logic [10:0] V_VIS  = 11'(VVIS);
    localparam logic [10:0] HS_BEG = 11'(HVIS + HFP);
    localparam logic [10:0] HS_END = 11'(HVIS + HFP + HSW);
    localparam logic [10:0] VS_BEG = 11'(VVIS + VFP);
    localparam logic [10:0] VS_END = 11'(VVIS + VFP + VSW);

    logic        adv;
    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        hs_act;
    logic        vs_act;
    logic        hvalid_next;
    logic        vvalid_next;
    logic        ls_next;
    logic        fs_next;

`ifdef VGA_TIMING_PIXCE_EN
    assign adv = pix_ce;
`else
    assign adv = 1'b1;
`endif

    // Next raster position. The reset position is the last blank pixel,
    // so the first advance after reset lands on (0,0).
    always_comb begin
        h_wrap = (hcnt == H_LAST);
        v_wrap = (vcnt == V_LAST);
        h_next = hcnt + 11'd1;
        v_next = vcnt;
        if (h_wrap) begin
            h_next = 11'd0;
            v_next = v_wrap ? 11'd0 : vcnt + 11'd1;
        end
    end

    // Flags are decoded from the next position so that each registered
    // flag lines up with the registered counter it describes. vsync only
    // follows v_next, which moves solely on the hcnt wrap.
    always_comb begin
        hs_act      = (h_next >= HS_BEG) && (h_next < HS_END);
        vs_act      = (v_next >= VS_BEG) && (v_next < VS_END);
        hvalid_next = (h_next < H_VIS);
        vvalid_next = (v_next < V_VIS);
        ls_next     = (h_next == 11'd0);
        fs_next     = (h_next == 11'd0) && (v_next == 11'd0);
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            hcnt        <= H_LAST;
            vcnt        <= V_LAST;
            hsync       <= ~HPOL;
            vsync       <= ~VPOL;
            hvalid      <= 1'b0;
            vvalid      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (adv) begin
            hcnt        <= h_next;
            vcnt        <= v_next;
            hsync       <= hs_act ? HPOL : ~HPOL;
            vsync       <= vs_act ? VPOL : ~VPOL;
            hvalid      <= hvalid_next;
            vvalid      <= vvalid_next;
            line_start  <= ls_next;
            frame_start <= fs_next;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing with a default-timing
// instance and a small-raster, active-low-sync instance.

module tb_vga_timing;

    localparam int BHV = 20, BHF = 3, BHS = 4, BHB = 5;
    localparam int BVV = 10, BVF = 2, BVS = 3, BVB = 2;
    localparam int BHT = BHV + BHF + BHS + BHB;
    localparam int BVT = BVV + BVF + BVS + BVB;
    localparam int ATOT = 1040 * 666;
    localparam int BTOT = BHT * BVT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, pix_ce, per_en;
    logic [10:0] hcnt_a, vcnt_a, hcnt_b, vcnt_b;
    logic hs_a, vs_a, hv_a, vv_a, ls_a, fs_a;
    logic hs_b, vs_b, hv_b, vv_b, ls_b, fs_b;

    int n_chk = 0;
    int n_fail = 0;

    vga_timing u_a (
        .clk(clk), .RSTn(rst_a),
`ifdef VGA_TIMING_PIXCE_EN
        .pix_ce(pix_ce),
`endif
        .hcnt(hcnt_a), .vcnt(vcnt_a),
        .hsync(hs_a), .vsync(vs_a),
        .hvalid(hv_a), .vvalid(vv_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing #(
        .HVIS(BHV), .HFP(BHF), .HSW(BHS), .HBP(BHB),
        .VVIS(BVV), .VFP(BVF), .VSW(BVS), .VBP(BVB),
        .HPOL(1'b0), .VPOL(1'b0)
    ) u_b (
        .clk(clk), .RSTn(rst_b),
`ifdef VGA_TIMING_PIXCE_EN
        .pix_ce(pix_ce),
`endif
        .hcnt(hcnt_b), .vcnt(vcnt_b),
        .hsync(hs_b), .vsync(vs_b),
        .hvalid(hv_b), .vvalid(vv_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: t is the pixel index within the frame (-1 = held in reset).
    function automatic logic [27:0] calc(input int t,
        input int hv, input int hf, input int hs, input int hb,
        input int vv, input int vf, input int vs, input int vb,
        input bit hp, input bit vp);
        int ht, h, v;
        bit hsy, vsy, hva, vva, ls, fs;
        ht = hv + hf + hs + hb;
        if (t < 0) begin
            h = ht - 1;
            v = vv + vf + vs + vb - 1;
            hsy = ~hp; vsy = ~vp;
            hva = 0; vva = 0; ls = 0; fs = 0;
        end else begin
            h = t % ht;
            v = t / ht;
            hsy = (h >= hv + hf && h < hv + hf + hs) ? hp : ~hp;
            vsy = (v >= vv + vf && v < vv + vf + vs) ? vp : ~vp;
            hva = h < hv;
            vva = v < vv;
            ls = (h == 0);
            fs = (t == 0);
        end
        return {11'(h), 11'(v), hsy, vsy, hva, vva, ls, fs};
    endfunction

    int t_a = -1;
    int t_b = -1;
    logic [27:0] qa[$];
    logic [27:0] qb[$];

    // Model: advance on each enabled edge, then post the expectation.
    initial forever begin
        @(posedge clk);
        if (rst_a === 1'b1 && pix_ce === 1'b1)
            t_a = (t_a < 0) ? 0 : (t_a + 1) % ATOT;
        if (rst_b === 1'b1 && pix_ce === 1'b1)
            t_b = (t_b < 0) ? 0 : (t_b + 1) % BTOT;
        #2;
        if (rst_a !== 1'b1) t_a = -1;
        if (rst_b !== 1'b1) t_b = -1;
        qa.push_back(calc(t_a, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1));
        qb.push_back(calc(t_b, BHV, BHF, BHS, BHB, BVV, BVF, BVS, BVB,
                          1'b0, 1'b0));
    end

    int cyc_a = 0, cyc_b = 0;
    bit seen_a = 0, seen_b = 0;

    // Monitor: pop and compare on every sample point.
    always @(negedge clk) begin
        logic [27:0] e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            chk("dut_a", {hcnt_a, vcnt_a, hs_a, vs_a, hv_a, vv_a, ls_a, fs_a}, e);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            chk("dut_b", {hcnt_b, vcnt_b, hs_b, vs_b, hv_b, vv_b, ls_b, fs_b}, e);
        end
        if (per_en) begin
            cyc_a++;
            cyc_b++;
            if (ls_a) begin
                if (seen_a) chk("line_period_a", cyc_a, 1040);
                seen_a = 1; cyc_a = 0;
            end
            if (fs_b) begin
                if (seen_b) chk("frame_period_b", cyc_b, BTOT);
                seen_b = 1; cyc_b = 0;
            end
        end else begin
            seen_a = 0; seen_b = 0; cyc_a = 0; cyc_b = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_a = 0; rst_b = 0; pix_ce = 1; per_en = 0;
        repeat (10) step();
        chk("rst_hcnt_a", hcnt_a, 1039);
        chk("rst_vcnt_a", vcnt_a, 665);
        chk("rst_sync_a", {hs_a, vs_a}, 0);
        chk("rst_sync_b", {hs_b, vs_b}, 2'b11);
        rst_a = 1; rst_b = 1; per_en = 1;
        step();
        chk("first_pos_a", {hcnt_a, vcnt_a}, 0);
        chk("first_flags_a", {hv_a, vv_a, ls_a, fs_a}, 4'hF);
        repeat (3200) step();
        per_en = 0;

        n = 0;
        while (t_b != 13 * BHT + 25 && n < 1000) begin
            step();
            n++;
        end
        chk("mid_reach_b", n < 1000, 1);
        chk("mid_sync_active_b", {hs_b, vs_b}, 2'b00);
        rst_b = 0;
        #1;
        chk("async_sync_idle_b", {hs_b, vs_b}, 2'b11);
        chk("async_pos_b", {hcnt_b, vcnt_b}, {11'd31, 11'd16});
        repeat ($urandom_range(2, 8)) step();
        rst_b = 1;
        step();
        chk("restart_b", {hcnt_b, vcnt_b, fs_b}, 23'd1);
        repeat (700) step();

        repeat ($urandom_range(1, 1500)) step();
        rst_a = 0;
        repeat ($urandom_range(1, 6)) step();
        rst_a = 1;
        repeat (1200) step();

`ifdef VGA_TIMING_PIXCE_EN
        repeat (1300) begin
            pix_ce = ~pix_ce;
            step();
        end
        pix_ce = 0;
        repeat (30) step();
        repeat (600) begin
            pix_ce = 1'($urandom);
            step();
        end
        pix_ce = 1;
`endif

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
